multiport_register_file: RTL
============================

# multiport_register_file

Parametrised successor to the single-write, two-read CPU register file: N read ports, two write ports with fixed priority, a hardwired zero register, and a per-register busy scoreboard for pipelined hazard detection. Sits in the decode stage of the pipelined datapath. Decode reads operands and queries busy bits. Writeback drives the write ports and retires pending destinations.

## Interface
Parameters:
- `WIDTH`, 32: data width of each register.
- `NREGS`, 32: number of registers; power of two, ≥ 2. `AW = $clog2(NREGS)`.
- `NREAD`, 2: number of read ports, 1..4.

Ports:
- `CLK`, in, 1: clock; all state updates on rising edge.
- `nRST`, in, 1: asynchronous, active-low reset.
- `wen`, in, [1:0]: per write port enable.
- `wsel`, in, [1:0][AW-1:0]: write register index per port.
- `wdat`, in, [1:0][WIDTH-1:0]: write data per port.
- `wclr`, in, [1:0]: when set with `wen[i]`, clears `busy[wsel[i]]`.
- `iss`, in, 1: issue strobe; marks `iss_sel` busy.
- `iss_sel`, in, [AW-1:0]: destination register being issued.
- `rsel`, in, [NREAD-1:0][AW-1:0]: read indices.
- `rdat`, out, [NREAD-1:0][WIDTH-1:0]: read data.
- `rbusy`, out, [NREAD-1:0]: busy bit of `rsel[k]`.
- `any_busy`, out, 1: OR of all busy bits.

## Operation
- Storage: `NREGS × WIDTH` flops plus an `NREGS`-bit busy vector.
- Register 0 is hardwired:
  - Writes to index 0 are ignored.
  - `rdat` for index 0 is always 0.
  - `busy[0]` is always 0; `iss` to 0 is ignored.
- Writes take effect on the rising edge when `wen[i]` = 1 and `wsel[i]` ≠ 0.
- Both ports targeting the same register in one cycle: port 1 wins the data. The clear is the OR of both ports' `wclr`.
- Busy update per register r, per edge:
  - Set if `iss && iss_sel == r`.
  - Else cleared if any port has `wen[i] && wclr[i] && wsel[i] == r`.
  - Simultaneous set and clear on r: set wins, because a new producer supersedes the retiring one.
- Reads are combinational: `rdat[k] = regs[rsel[k]]`, `rbusy[k] = busy[rsel[k]]`, subject to the bypass rule below.
- Out-of-range indices are impossible, since `NREGS` is a power of two.

## Timing
- Reset (`nRST` = 0, asynchronous):
  - All registers and busy bits clear immediately.
  - `rdat` = 0, `rbusy` = 0, `any_busy` = 0 while asserted.
- Reset deasserted mid-operation: the first rising edge after deassertion performs normal writes. Writes or issues presented during reset are lost.
- Write latency: 1 edge. Data is visible on `rdat` in the cycle after the write edge. With bypass enabled, it is also visible in the write cycle itself.
- Busy latency:
  - `iss` on edge n → `rbusy` = 1 from cycle n+1.
  - A clearing write on edge m → `rbusy` = 0 from cycle m+1, unless bypassed.
- No handshake or backpressure. Every `wen` and `iss` is accepted unconditionally each cycle.

## Configuration
- Macro `RF_BYPASS_EN`.
- Defined: write-to-read forwarding.
  - If `wen[i]` and `wsel[i] == rsel[k]` ≠ 0, then `rdat[k] = wdat[i]` in the same cycle, with port 1 taking priority.
  - `rbusy[k]` reads 0 in that cycle if the matching port has `wclr[i]` = 1 and there is no same-cycle `iss` to that register.
  - Forwarding is purely combinational; stored state is unchanged.
- Undefined: reads return stored contents only; same-cycle writes are invisible until the next cycle. Use this when writeback and decode are split across clock phases elsewhere.

## Test plan
- Reset: drive `nRST` = 0 mid-cycle after filling r5 = 0xDEADBEEF → `rdat` for r5 reads 0 immediately, `any_busy` = 0, no clock edge needed.
- Zero register: write 0x12345678 to r0 on both ports, then `iss` to r0 → `rdat` for r0 = 0 and `rbusy` = 0 on all ports.
- Write conflict: port 0 writes 0xAAAA to r7, port 1 writes 0x5555 to r7, same edge → next cycle r7 = 0x5555.
- Scoreboard:
  - Issue to r3 → `rbusy` for r3 = 1 next cycle.
  - Then, in one cycle, `iss` to r3 together with `wen`/`wclr` to r3 → r3 remains busy.
  - A later clearing write → `rbusy` = 0.
- Bypass (`RF_BYPASS_EN` defined): `rsel[0]` = 9 while port 0 writes 0xCAFEF00D to r9 with `wclr` → `rdat[0]` = 0xCAFEF00D and `rbusy[0]` = 0 in the same cycle. With the macro undefined, the old value and `rbusy` = 1 are seen until the next cycle.
- Parameter sweep: `NREAD` = 4, `NREGS` = 16, `WIDTH` = 64 → random write/read traffic matches the reference model for all ports.

Source files
------------

// File: rtl/multiport_register_file.sv
// multiport_register_file: NREAD combinational read ports, two prioritised
// write ports, hardwired zero register and a per-register busy scoreboard
// for decode-stage hazard detection.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding).
module multiport_register_file #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [1:0]                  wen,
  input  logic [1:0][AW-1:0]          wsel,
  input  logic [1:0][WIDTH-1:0]       wdat,
  input  logic [1:0]                  wclr,
  input  logic                        iss,
  input  logic [AW-1:0]               iss_sel,
  input  logic [NREAD-1:0][AW-1:0]    rsel,
  output logic [NREAD-1:0][WIDTH-1:0] rdat,
  output logic [NREAD-1:0]            rbusy,
  output logic                        any_busy
);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            busy;
  logic [NREGS-1:0]            busy_nxt;

  // Register storage; port 1 overrides port 0 on a shared target, r0 is never written
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      regs <= '0;
    end else begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (wen[1] && (wsel[1] == AW'(r))) begin
          regs[r] <= wdat[1];
        end else if (wen[0] && (wsel[0] == AW'(r))) begin
          regs[r] <= wdat[0];
        end
      end
    end
  end

  // Busy next state: a new issue supersedes a retiring producer on the same register
  always_comb begin
    busy_nxt    = busy;
    busy_nxt[0] = 1'b0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (iss && (iss_sel == AW'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if ((wen[0] && wclr[0] && (wsel[0] == AW'(r))) ||
                   (wen[1] && wclr[1] && (wsel[1] == AW'(r)))) begin
        busy_nxt[r] = 1'b0;
      end
    end
  end

  // Busy scoreboard register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Combinational read ports, optionally forwarding same-cycle writeback
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      rdat[k]  = regs[rsel[k]];
      rbusy[k] = busy[rsel[k]];
`ifdef RF_BYPASS_EN
      // Forwarding is suppressed during reset so outputs stay zero
      if (nRST && (rsel[k] != '0)) begin
        if (wen[1] && (wsel[1] == rsel[k])) begin
          rdat[k] = wdat[1];
        end else if (wen[0] && (wsel[0] == rsel[k])) begin
          rdat[k] = wdat[0];
        end
        if (!(iss && (iss_sel == rsel[k])) &&
            ((wen[1] && wclr[1] && (wsel[1] == rsel[k])) ||
             (wen[0] && wclr[0] && (wsel[0] == rsel[k])))) begin
          rbusy[k] = 1'b0;
        end
      end
`endif
    end
  end

  assign any_busy = |busy;

endmodule
